// File: rtl/skinny_pkg.sv
// SKINNY-128 shared definitions for the masked round core.
// Byte b of a 128-bit word sits at [127-8b -: 8]; share s at [128s +: 128].
package skinny_pkg;

    localparam logic [5:0] RC_INIT    = 6'h01;
    localparam logic [7:0] ROW2_CONST = 8'h02;

    localparam int PT [16] = '{9, 15, 8, 13, 10, 14, 12, 11,
                               0, 1, 2, 3, 4, 5, 6, 7};
    localparam int SR [16] = '{0, 1, 2, 3, 7, 4, 5, 6,
                               10, 11, 8, 9, 13, 14, 15, 12};

    function automatic int rnd_w(int nshares, int unroll);
        return unroll * 128 * nshares * (nshares - 1) / 2;
    endfunction

    function automatic int share_lsb(int s);
        return 128 * s;
    endfunction

    function automatic int byte_msb(int b);
        return 127 - 8 * b;
    endfunction

    function automatic logic [7:0] get_byte(logic [127:0] w, int b);
        return w[byte_msb(b) -: 8];
    endfunction

    function automatic logic [5:0] lfsr_next(logic [5:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    function automatic logic [7:0] tk2_lfsr(logic [7:0] x);
        return {x[6:0], x[7] ^ x[5]};
    endfunction

    function automatic logic [7:0] tk3_lfsr(logic [7:0] x);
        return {x[0] ^ x[6], x[7:1]};
    endfunction

    // Bit wirings between the NOR/XOR stages of the 8-bit S-box
    function automatic logic [7:0] sb_perm(logic [7:0] x);
        return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
    endfunction

    function automatic logic [7:0] sb_swap(logic [7:0] x);
        return {x[7:3], x[1], x[2], x[0]};
    endfunction

endpackage

// File: rtl/skinny_masked_round.sv
// One masked SKINNY-128-384 round over all shares, plus tweakey update.
// Purely combinational; chained UNROLL times by the core.
module skinny_masked_round
    import skinny_pkg::*;
#(
    parameter int NSHARES = 2,
    localparam int NPAIR = NSHARES * (NSHARES - 1) / 2,
    localparam int SW = 128 * NSHARES
) (
    input  logic [SW-1:0]        st_i,
    input  logic [127:0]         tk1_i,
    input  logic [127:0]         tk2_i,
    input  logic [SW-1:0]        tk3_i,
    input  logic [5:0]           rc_i,
    input  logic [128*NPAIR-1:0] rnd_i,
    output logic [SW-1:0]        st_o,
    output logic [127:0]         tk1_o,
    output logic [127:0]         tk2_o,
    output logic [SW-1:0]        tk3_o
);

    typedef logic [NSHARES-1:0][7:0] shb_t;

    function automatic logic [NSHARES-1:0] dom_and(
        logic [NSHARES-1:0] a,
        logic [NSHARES-1:0] b,
        logic [NPAIR-1:0]   r
    );
        logic [NSHARES-1:0] c;
        int p;
        c = a & b;
        p = 0;
        for (int i = 0; i < NSHARES; i++) begin
            for (int j = i + 1; j < NSHARES; j++) begin
                c[i] = c[i] ^ (a[i] & b[j]) ^ r[p];
                c[j] = c[j] ^ (a[j] & b[i]) ^ r[p];
                p++;
            end
        end
        return c;
    endfunction

    // Cells 2m and 2m+1 form NOR stage m; inversion lands on share 0 only
    function automatic shb_t sbox(shb_t v, logic [8*NPAIR-1:0] r);
        shb_t o;
        logic [NSHARES-1:0] a, b, z;
        int ia, iz;
        o = v;
        for (int c = 0; c < 8; c++) begin
            if (c != 0 && c % 2 == 0) begin
                for (int s = 0; s < NSHARES; s++)
                    o[s] = sb_perm(o[s]);
            end
            ia = (c % 2 == 1) ? 7 : 3;
            iz = (c % 2 == 1) ? 4 : 0;
            for (int s = 0; s < NSHARES; s++) begin
                a[s] = o[s][ia];
                b[s] = o[s][ia-1];
            end
            a[0] = ~a[0];
            b[0] = ~b[0];
            z = dom_and(a, b, r[c*NPAIR +: NPAIR]);
            for (int s = 0; s < NSHARES; s++)
                o[s][iz] = o[s][iz] ^ z[s];
        end
        for (int s = 0; s < NSHARES; s++)
            o[s] = sb_swap(o[s]);
        return o;
    endfunction

    shb_t in_b [16];
    shb_t ark  [16];
    shb_t sr   [16];
    shb_t mc   [16];

    always_comb begin
        for (int b = 0; b < 16; b++)
            for (int s = 0; s < NSHARES; s++)
                in_b[b][s] = st_i[share_lsb(s) + byte_msb(b) -: 8];

        for (int b = 0; b < 16; b++)
            ark[b] = sbox(in_b[b], rnd_i[b*8*NPAIR +: 8*NPAIR]);

        ark[0][0] = ark[0][0] ^ {4'h0, rc_i[3:0]};
        ark[4][0] = ark[4][0] ^ {6'h00, rc_i[5:4]};
        ark[8][0] = ark[8][0] ^ ROW2_CONST;

        for (int b = 0; b < 8; b++) begin
            ark[b][0] = ark[b][0] ^ get_byte(tk1_i, b) ^ get_byte(tk2_i, b);
            for (int s = 0; s < NSHARES; s++)
                ark[b][s] = ark[b][s]
                          ^ get_byte(tk3_i[share_lsb(s) +: 128], b);
        end

        for (int b = 0; b < 16; b++)
            sr[b] = ark[SR[b]];

        for (int c = 0; c < 4; c++) begin
            mc[c]      = sr[c] ^ sr[8+c] ^ sr[12+c];
            mc[4+c]    = sr[c];
            mc[8+c]    = sr[4+c] ^ sr[8+c];
            mc[12+c]   = sr[c] ^ sr[8+c];
        end

        st_o = '0;
        for (int b = 0; b < 16; b++)
            for (int s = 0; s < NSHARES; s++)
                st_o[share_lsb(s) + byte_msb(b) -: 8] = mc[b][s];
    end

    always_comb begin
        tk1_o = '0;
        tk2_o = '0;
        tk3_o = '0;
        for (int b = 0; b < 16; b++) begin
            tk1_o[byte_msb(b) -: 8] = get_byte(tk1_i, PT[b]);
            tk2_o[byte_msb(b) -: 8] = (b < 8)
                ? tk2_lfsr(get_byte(tk2_i, PT[b]))
                : get_byte(tk2_i, PT[b]);
            for (int s = 0; s < NSHARES; s++)
                tk3_o[share_lsb(s) + byte_msb(b) -: 8] = (b < 8)
                    ? tk3_lfsr(get_byte(tk3_i[share_lsb(s) +: 128], PT[b]))
                    : get_byte(tk3_i[share_lsb(s) +: 128], PT[b]);
        end
    end

endmodule

// File: rtl/skinny_masked_core.sv
// Masked SKINNY-128-384 core: valid/ready in and out, fresh randomness
// per busy cycle, state wiped once the ciphertext is taken.
module skinny_masked_core
    import skinny_pkg::*;
#(
    parameter int NSHARES = 2,
    parameter int ROUNDS = 40,
    parameter int UNROLL = 1,
    localparam int RND_W = rnd_w(NSHARES, UNROLL)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [128*NSHARES-1:0]  input_i,
    input  logic [128*NSHARES-1:0]  key_i,
    input  logic [127:0]            tweak1_i,
    input  logic [127:0]            tweak2_i,
    input  logic [RND_W-1:0]        rnd_i,
    output logic                    rnd_req_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [128*NSHARES-1:0]  cipher_o
);

    localparam int SW = 128 * NSHARES;
    localparam int STEPS = ROUNDS / UNROLL;
    localparam int CW = $clog2(STEPS + 1);
    localparam int RPR = RND_W / UNROLL;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [SW-1:0]   st_q, tk3_q;
    logic [127:0]    tk1_q, tk2_q;
    logic [5:0]      rc_q;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q, out_valid_q, rnd_req_q;

    logic [SW-1:0]   st_c  [UNROLL+1];
    logic [SW-1:0]   tk3_c [UNROLL+1];
    logic [127:0]    tk1_c [UNROLL+1];
    logic [127:0]    tk2_c [UNROLL+1];
    logic [5:0]      rc_c  [UNROLL+1];

    assign st_c[0]  = st_q;
    assign tk1_c[0] = tk1_q;
    assign tk2_c[0] = tk2_q;
    assign tk3_c[0] = tk3_q;
    assign rc_c[0]  = rc_q;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        skinny_masked_round #(.NSHARES(NSHARES)) u_round (
            .st_i  (st_c[u]),
            .tk1_i (tk1_c[u]),
            .tk2_i (tk2_c[u]),
            .tk3_i (tk3_c[u]),
            .rc_i  (rc_c[u]),
            .rnd_i (rnd_i[u*RPR +: RPR]),
            .st_o  (st_c[u+1]),
            .tk1_o (tk1_c[u+1]),
            .tk2_o (tk2_c[u+1]),
            .tk3_o (tk3_c[u+1])
        );
        assign rc_c[u+1] = lfsr_next(rc_c[u]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rnd_req_q   <= 1'b0;
            st_q        <= '0;
            tk1_q       <= '0;
            tk2_q       <= '0;
            tk3_q       <= '0;
            rc_q        <= '0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        st_q       <= input_i;
                        tk1_q      <= tweak1_i;
                        tk2_q      <= tweak2_i;
                        tk3_q      <= key_i;
                        rc_q       <= RC_INIT;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        rnd_req_q  <= 1'b1;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    st_q  <= st_c[UNROLL];
                    tk1_q <= tk1_c[UNROLL];
                    tk2_q <= tk2_c[UNROLL];
                    tk3_q <= tk3_c[UNROLL];
                    rc_q  <= rc_c[UNROLL];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(STEPS - 1)) begin
                        rnd_req_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Wipe all secret-bearing registers on handoff
                    if (out_ready_i) begin
                        st_q        <= '0;
                        tk1_q       <= '0;
                        tk2_q       <= '0;
                        tk3_q       <= '0;
                        rc_q        <= '0;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign rnd_req_o   = rnd_req_q;
    assign cipher_o    = out_valid_q ? st_q : '0;

endmodule

// File: tb/tb_skinny_masked_core.sv
// Directed bench for skinny_masked_core using the SKINNY-128-384 test vector.
// Two instances: 2 shares/1 round per clock and 3 shares/4 rounds per clock.
module tb_skinny_masked_core;

    localparam logic [127:0] TK1 = 128'hdf889548cfc7ea52d296339301797449;
    localparam logic [127:0] TK2 = 128'hab588a34a47f1ab2dfe9c8293fbea9a5;
    localparam logic [127:0] TK3 = 128'hab1afac2611012cd8cef952618c3ebe8;
    localparam logic [127:0] PT  = 128'ha3994b66ad85a3459f44e92b08f550cb;
    localparam logic [127:0] CT  = 128'h94ecf589e2017c601b38c6346a10dcfa;
    localparam int LAT_A = 56;
    localparam int LAT_B = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [127:0] t1, t2;

    logic a_in_valid, a_in_ready, a_rnd_req, a_out_valid, a_out_ready;
    logic [255:0] a_input, a_key, a_cipher;
    logic [127:0] a_rnd;

    logic b_in_valid, b_in_ready, b_rnd_req, b_out_valid, b_out_ready;
    logic [383:0] b_input, b_key, b_cipher;
    logic [1535:0] b_rnd;

    int total = 0;
    int bad = 0;
    int unsigned edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    skinny_masked_core #(.NSHARES(2), .ROUNDS(56), .UNROLL(1)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .input_i(a_input), .key_i(a_key),
        .tweak1_i(t1), .tweak2_i(t2),
        .rnd_i(a_rnd), .rnd_req_o(a_rnd_req),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .cipher_o(a_cipher)
    );

    skinny_masked_core #(.NSHARES(3), .ROUNDS(56), .UNROLL(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .input_i(b_input), .key_i(b_key),
        .tweak1_i(t1), .tweak2_i(t2),
        .rnd_i(b_rnd), .rnd_req_o(b_rnd_req),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .cipher_o(b_cipher)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] comb_a(logic [255:0] x);
        return x[127:0] ^ x[255:128];
    endfunction

    function automatic logic [127:0] comb_b(logic [383:0] x);
        return x[127:0] ^ x[255:128] ^ x[383:256];
    endfunction

    task automatic load_a(input logic [127:0] ps1, input logic [127:0] ks1);
        a_input = {ps1, PT ^ ps1};
        a_key   = {ks1, TK3 ^ ks1};
        t1 = TK1;
        t2 = TK2;
    endtask

    // Accept one block on A and run until out_valid or the cycle budget ends
    task automatic run_a(input bit rnd_on, output int lat, output int req);
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        a_input = {rand128(), rand128()};
        a_key = {rand128(), rand128()};
        lat = 0;
        req = 0;
        while (!a_out_valid && lat < 200) begin
            a_rnd = rnd_on ? rand128() : '0;
            req += int'(a_rnd_req);
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (a_in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b want=1", a_in_ready);
        end
        total++;
        if (a_out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b want=0", a_out_valid);
        end
        total++;
        if (a_rnd_req !== 1'b0) begin
            bad++; $display("FAIL reset_rnd_req got=%b want=0", a_rnd_req);
        end
        total++;
        if (a_cipher !== 256'h0) begin
            bad++; $display("FAIL reset_cipher got=%h want=0", a_cipher);
        end
        total++;
        if (b_in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_b_in_ready got=%b want=1", b_in_ready);
        end
        total++;
        if (b_cipher !== 384'h0) begin
            bad++; $display("FAIL reset_b_cipher got=%h want=0", b_cipher);
        end
    endtask

    task automatic test_plain_vector();
        int lat, req;
        load_a('0, '0);
        run_a(1'b0, lat, req);
        total++;
        if (lat !== LAT_A) begin
            bad++; $display("FAIL plain_latency got=%0d want=%0d", lat, LAT_A);
        end
        total++;
        if (req !== LAT_A) begin
            bad++; $display("FAIL plain_rnd_req got=%0d want=%0d", req, LAT_A);
        end
        total++;
        if (comb_a(a_cipher) !== CT) begin
            bad++; $display("FAIL plain_ct got=%h want=%h", comb_a(a_cipher), CT);
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        total++;
        if (a_out_valid !== 1'b0) begin
            bad++; $display("FAIL plain_handshake got=%b want=0", a_out_valid);
        end
    endtask

    task automatic test_masked_random();
        int lat, req;
        for (int k = 0; k < 2; k++) begin
            load_a(rand128(), rand128());
            run_a(1'b1, lat, req);
            total++;
            if (lat !== LAT_A) begin
                bad++; $display("FAIL masked_a_latency got=%0d want=%0d", lat, LAT_A);
            end
            total++;
            if (comb_a(a_cipher) !== CT) begin
                bad++; $display("FAIL masked_a_ct got=%h want=%h", comb_a(a_cipher), CT);
            end
            a_out_ready = 1'b1;
            tick();
            a_out_ready = 1'b0;
        end
    endtask

    task automatic test_shares3_unroll4();
        logic [127:0] p1, p2, k1, k2;
        int lat;
        p1 = rand128(); p2 = rand128();
        k1 = rand128(); k2 = rand128();
        b_input = {p2, p1, PT ^ p1 ^ p2};
        b_key = {k2, k1, TK3 ^ k1 ^ k2};
        t1 = TK1;
        t2 = TK2;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        b_input = '0;
        lat = 0;
        while (!b_out_valid && lat < 100) begin
            for (int w = 0; w < 48; w++)
                b_rnd[32*w +: 32] = $urandom;
            tick();
            lat++;
        end
        total++;
        if (lat !== LAT_B) begin
            bad++; $display("FAIL b_latency got=%0d want=%0d", lat, LAT_B);
        end
        total++;
        if (comb_b(b_cipher) !== CT) begin
            bad++; $display("FAIL b_ct got=%h want=%h", comb_b(b_cipher), CT);
        end
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        total++;
        if (b_cipher !== 384'h0) begin
            bad++; $display("FAIL b_wipe got=%h want=0", b_cipher);
        end
    endtask

    task automatic test_backpressure();
        int lat, req;
        load_a(rand128(), rand128());
        run_a(1'b1, lat, req);
        for (int c = 0; c < 20; c++) begin
            a_in_valid = 1'b1;
            a_input = {rand128(), rand128()};
            total++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_flags cyc=%0d got v=%b r=%b want v=1 r=0",
                         c, a_out_valid, a_in_ready);
            end
            total++;
            if (comb_a(a_cipher) !== CT) begin
                bad++; $display("FAIL bp_ct cyc=%0d got=%h want=%h", c, comb_a(a_cipher), CT);
            end
            tick();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        total++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got v=%b r=%b want v=0 r=1", a_out_valid, a_in_ready);
        end
        total++;
        if (a_cipher !== 256'h0) begin
            bad++; $display("FAIL bp_wipe got=%h want=0", a_cipher);
        end
        tick();
        total++;
        if (a_rnd_req !== 1'b0 || a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_queue got req=%b r=%b want req=0 r=1", a_rnd_req, a_in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat, req;
        load_a(rand128(), rand128());
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            a_rnd = rand128();
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_rnd_req !== 1'b0) begin
            bad++;
            $display("FAIL midrst_flags got r=%b v=%b req=%b want 1 0 0",
                     a_in_ready, a_out_valid, a_rnd_req);
        end
        total++;
        if (a_cipher !== 256'h0) begin
            bad++; $display("FAIL midrst_cipher got=%h want=0", a_cipher);
        end
        load_a(rand128(), rand128());
        run_a(1'b1, lat, req);
        total++;
        if (lat !== LAT_A) begin
            bad++; $display("FAIL midrst_latency got=%0d want=%0d", lat, LAT_A);
        end
        total++;
        if (comb_a(a_cipher) !== CT) begin
            bad++; $display("FAIL midrst_ct got=%h want=%h", comb_a(a_cipher), CT);
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int unsigned acc [3];
        int accepts, req, wait_n;
        load_a(rand128(), rand128());
        a_in_valid = 1'b1;
        a_out_ready = 1'b1;
        accepts = 0;
        req = 0;
        for (int i = 0; i < 400 && accepts < 3; i++) begin
            if (a_in_ready) begin
                acc[accepts] = edge_cnt + 1;
                accepts++;
            end
            if (a_out_valid) begin
                total++;
                if (comb_a(a_cipher) !== CT) begin
                    bad++; $display("FAIL b2b_ct got=%h want=%h", comb_a(a_cipher), CT);
                end
            end
            a_rnd = rand128();
            tick();
            if (accepts == 1 || accepts == 2)
                req += int'(a_rnd_req);
        end
        a_in_valid = 1'b0;
        total++;
        if (accepts !== 3) begin
            bad++; $display("FAIL b2b_accepts got=%0d want=3", accepts);
        end else begin
            total++;
            if (acc[1] - acc[0] !== LAT_A + 2) begin
                bad++; $display("FAIL b2b_period1 got=%0d want=%0d", acc[1] - acc[0], LAT_A + 2);
            end
            total++;
            if (acc[2] - acc[1] !== LAT_A + 2) begin
                bad++; $display("FAIL b2b_period2 got=%0d want=%0d", acc[2] - acc[1], LAT_A + 2);
            end
        end
        total++;
        if (req !== 2 * LAT_A) begin
            bad++; $display("FAIL b2b_rnd_req got=%0d want=%0d", req, 2 * LAT_A);
        end
        wait_n = 0;
        while (!a_out_valid && wait_n < 200) begin
            a_rnd = rand128();
            tick();
            wait_n++;
        end
        total++;
        if (comb_a(a_cipher) !== CT) begin
            bad++; $display("FAIL b2b_last_ct got=%h want=%h", comb_a(a_cipher), CT);
        end
        tick();
        a_out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        t1 = '0; t2 = '0;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_input = '0; a_key = '0; a_rnd = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_input = '0; b_key = '0; b_rnd = '0;
        test_reset();
        test_plain_vector();
        test_masked_random();
        test_shares3_unroll4();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skinny_masked_core.md
Name: skinny_masked_core

Overview:
- Parametrised successor to the team's 2-share SKINNY-128-384 round core.
- Generalised in share count (NSHARES), round count (ROUNDS: 40 for -384+, 56 for full -384) and rounds unrolled per clock (UNROLL).
- Adds valid/ready handshakes on input and output, per-cycle fresh randomness for the masked nonlinear layer, and a state wipe after output.
- Sits between the UART/AEAD controller and the share generator. TK3 (key) and plaintext arrive shared; TK1/TK2 arrive unshared.

Parameters:
NSHARES, 2, number of Boolean shares of state and TK3 (2..4)
ROUNDS, 40, total SKINNY rounds; must be a multiple of UNROLL
UNROLL, 1, rounds computed per clock (1, 2, 4, 8)
RND_W, UNROLL*128*NSHARES*(NSHARES-1)/2, fresh random bits consumed per busy cycle (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
in_valid_i  in  1  input block valid
in_ready_o  out  1  core can accept a block
input_i  in  128*NSHARES  plaintext shares; share s at [128s+127:128s]
key_i  in  128*NSHARES  TK3 shares, same layout
tweak1_i  in  128  TK1, unshared
tweak2_i  in  128  TK2, unshared
rnd_i  in  RND_W  fresh randomness; must be valid in every busy cycle
rnd_req_o  out  1  high in cycles where rnd_i is consumed
out_valid_o  out  1  ciphertext valid
out_ready_i  in  1  sink accepts ciphertext
cipher_o  out  128*NSHARES  ciphertext shares

Behaviour:
- Reset (rst_i=1 at a clock edge): FSM to IDLE. in_ready_o=1, out_valid_o=0, rnd_req_o=0, cipher_o=0. All state/key/tweak registers zeroed. Reset takes priority over all other events, including mid-operation; partial results are discarded.
- FSM states and transitions:
  - IDLE: in_ready_o=1. On in_valid_i&in_ready_o at edge k: load state, TK1/TK2/TK3, round constant LFSR=6'h01 and round counter=0, then go to BUSY.
  - BUSY: in_ready_o=0, rnd_req_o=1. Each edge applies UNROLL rounds and increments the counter. After edge k+ROUNDS/UNROLL, go to DONE.
  - DONE: out_valid_o=1 and cipher_o holds the shares; both stay stable until out_ready_i. On out_valid_o&out_ready_i, wipe state/key regs to 0 and go to IDLE. in_ready_o stays low in DONE; there is no overlap between blocks.
- Latency: accept edge to out_valid_o high is exactly ROUNDS/UNROLL edges. For example, 40 for the default parameters and 10 with UNROLL=4.
- Each round is SubCells (masked) → AddConstants → AddRoundTweakey → ShiftRows → MixColumns, matching the SKINNY spec bit ordering. Byte 0 is input_i[127:120].
- Round constant LFSR: c ← {c[4:0], c[5]^c[4]^1}, advanced once per round, i.e. UNROLL times per edge.
- Constants (c[3:0], c[5:4], 0x02) and the unshared TK1^TK2 rows 0-1 are XORed into share 0 only. The TK3 share s rows 0-1 are XORed into share s.
- TK schedule per round: permutation PT on all tweakeys. Rows 0-1 of TK2 use LFSR x7..x0 → x6..x0,x7^x5. Rows 0-1 of TK3 share-wise use x0^x6,x7..x1. Both LFSRs are linear, so they are applied to each share.
- Masked S-box: the 8 chained (~x&~y)^z cells use a DOM-indep AND gadget.
  - Each cell consumes NSHARES*(NSHARES-1)/2 bits of rnd_i, sliced in fixed order: round, then byte, then cell, then share pair.
  - Gadgets are combinational: probing-secure, not glitch-robust.
- rnd_i is ignored outside BUSY. Its value never affects the recombined result; with rnd_i=0 the output still recombines correctly.
- in_valid_i asserted while busy is ignored, with no queueing. Input data needs to be stable only in the accept cycle.

Decomposition:
- Package skinny_pkg holds:
  - the PT byte permutation as a constant index array;
  - the LFSR initial value 6'h01;
  - the 0x02 row-2 constant;
  - the function rnd_w(nshares, unroll);
  - the byte and share slice helpers.
- One sub-module, skinny_masked_round, holds the combinational logic for one round across all shares, including the tweakey update. The top instantiates UNROLL copies in a generate chain and holds the FSM, counter and LFSR.

Test Plan:
1. ROUNDS=56, NSHARES=2, share1=0, rnd_i=0.
   - Stimulus: TK1=df889548cfc7ea52d296339301797449, TK2=ab588a34a47f1ab2dfe9c8293fbea9a5, TK3=ab1afac2611012cd8cef952618c3ebe8, PT=a3994b66ad85a3459f44e92b08f550cb.
   - Required: share0^share1 = 94ecf589e2017c601b38c6346a10dcfa, with out_valid_o exactly 56 edges after accept.
2. Same vector with random shares and random rnd_i each cycle, for NSHARES=2,3 and UNROLL=1,4. Required: identical recombined ciphertext, latency 56 and 14.
3. Backpressure: hold out_ready_i=0 for 20 cycles. Required: cipher_o stable, in_ready_o=0, and a second in_valid_i is ignored. Release → one-cycle handshake, registers read 0 next cycle, in_ready_o=1.
4. Reset mid-operation: assert rst_i at busy cycle 7. Required: next cycle in_ready_o=1, out_valid_o=0, cipher_o=0. A fresh block then yields the correct result.
5. Back-to-back blocks with out_ready_i tied 1. Required: accept-to-accept period = ROUNDS/UNROLL+2 edges, and rnd_req_o high exactly ROUNDS/UNROLL cycles per block.
